// File: rtl/remodel_sram_arbiter.sv
// Round-robin arbiter sharing one SRAM port between NumReq requesters.
// Reads are tracked in a Latency-deep tag pipeline so each response returns to its requester.
module remodel_sram_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  localparam int unsigned BeWidth  = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  input  logic [NumReq-1:0]                    req_we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]     req_addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     req_wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]       req_be_i,
  output logic [NumReq-1:0]                    rsp_valid_o,
  output logic [DataWidth-1:0]                 rsp_rdata_o,
  output logic                                 sram_req_o,
  output logic                                 sram_we_o,
  output logic [AddrWidth-1:0]                 sram_addr_o,
  output logic [DataWidth-1:0]                 sram_wdata_o,
  output logic [BeWidth-1:0]                   sram_be_o,
  input  logic [DataWidth-1:0]                 sram_rdata_i,
  output logic [IdxWidth-1:0]                  dbg_rr_o
);

  // Handshake: a requester holds req_valid_i and its payload stable until it sees
  // req_ready_o; the transfer happens in the cycle both are high. Responses have no
  // backpressure and must be taken in the cycle rsp_valid_o is shown.

  logic [IdxWidth-1:0]              rr_q;
  logic [NumReq-1:0]                valid_eff;
  logic                             gnt_vld;
  logic [IdxWidth-1:0]              gnt_idx;
  logic [IdxWidth-1:0]              cand_idx;
  logic [Latency-1:0]               vld_q;
  logic [Latency-1:0][IdxWidth-1:0] idx_q;

  // Reset masks every request so no grant or SRAM access leaks out while held.
  assign valid_eff = rst_i ? '0 : req_valid_i;

  // Walk from the farthest candidate back to rr_q+1 so the nearest valid one wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = rr_q;
    cand_idx = '0;
    for (int k = NumReq; k >= 1; k--) begin
      cand_idx = IdxWidth'((int'(rr_q) + k) % NumReq);
      if (valid_eff[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  always_comb begin
    req_ready_o  = '0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (gnt_vld) begin
      req_ready_o[gnt_idx] = 1'b1;
      sram_we_o            = req_we_i[gnt_idx];
      sram_addr_o          = req_addr_i[gnt_idx];
      sram_wdata_o         = req_wdata_i[gnt_idx];
      sram_be_o            = req_be_i[gnt_idx];
    end
  end

  assign sram_req_o = gnt_vld;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= IdxWidth'(NumReq - 1);
    end else if (gnt_vld) begin
      rr_q <= gnt_idx;
    end
  end

  // Tag pipeline shifts every cycle; there is no stall because the SRAM has none.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q[0] <= gnt_vld && !req_we_i[gnt_idx];
      idx_q[0] <= gnt_idx;
      for (int k = 1; k < Latency; k++) begin
        vld_q[k] <= vld_q[k-1];
        idx_q[k] <= idx_q[k-1];
      end
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (vld_q[Latency-1]) begin
      rsp_valid_o[idx_q[Latency-1]] = 1'b1;
    end
  end

  assign rsp_rdata_o = sram_rdata_i;
  assign dbg_rr_o    = rr_q;

endmodule

// File: tb/tb_remodel_sram_arbiter.sv
// Bench for remodel_sram_arbiter: three instances (Latency 1, 2, 3) each with a small SRAM
// model; expected responses are queued at grant time and popped when responses appear.
module tb_remodel_sram_arbiter;

  localparam int EW = 32 + 4 + 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  logic [3:0]            valid1, valid2, valid3;
  logic [3:0]            we;
  logic [3:0][9:0]       addr;
  logic [3:0][127:0]     wdata;
  logic [3:0][15:0]      be;

  logic [3:0]   ready1, ready2, ready3;
  logic [3:0]   rspv1, rspv2, rspv3;
  logic [127:0] rdo1, rdo2, rdo3;
  logic         sreq1, sreq2, sreq3;
  logic         swe1, swe2, swe3;
  logic [9:0]   saddr1, saddr2, saddr3;
  logic [127:0] swd1, swd2, swd3;
  logic [15:0]  sbe1, sbe2, sbe3;
  logic [127:0] rdata1, rdata2, rdata3;
  logic [1:0]   rr1, rr2, rr3;

  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];
  logic [EW-1:0] exp_q3[$];

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

  remodel_sram_arbiter #(.Latency(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid1), .req_ready_o(ready1), .req_we_i(we),
    .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be), .rsp_valid_o(rspv1),
    .rsp_rdata_o(rdo1), .sram_req_o(sreq1), .sram_we_o(swe1), .sram_addr_o(saddr1),
    .sram_wdata_o(swd1), .sram_be_o(sbe1), .sram_rdata_i(rdata1), .dbg_rr_o(rr1));

  remodel_sram_arbiter #(.Latency(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid2), .req_ready_o(ready2), .req_we_i(we),
    .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be), .rsp_valid_o(rspv2),
    .rsp_rdata_o(rdo2), .sram_req_o(sreq2), .sram_we_o(swe2), .sram_addr_o(saddr2),
    .sram_wdata_o(swd2), .sram_be_o(sbe2), .sram_rdata_i(rdata2), .dbg_rr_o(rr2));

  remodel_sram_arbiter #(.Latency(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid3), .req_ready_o(ready3), .req_we_i(we),
    .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be), .rsp_valid_o(rspv3),
    .rsp_rdata_o(rdo3), .sram_req_o(sreq3), .sram_we_o(swe3), .sram_addr_o(saddr3),
    .sram_wdata_o(swd3), .sram_be_o(sbe3), .sram_rdata_i(rdata3), .dbg_rr_o(rr3));

  function automatic logic [127:0] pat(input logic [9:0] a);
    return {4{22'h2A5F1, a}};
  endfunction

  function automatic logic [EW-1:0] mk(input int due, input logic [3:0] oh, input logic [127:0] d);
    return {32'(due), oh, d};
  endfunction

  // SRAM models: a real byte-writable memory for Latency 1, address patterns for 2 and 3.
  logic [127:0] mem1 [1024];
  logic [127:0] r2_0, r2_1, r3_0, r3_1, r3_2;

  initial for (int i = 0; i < 1024; i++) mem1[i] = pat(10'(i));

  always @(posedge clk) begin
    if (sreq1 && swe1) begin
      for (int b = 0; b < 16; b++)
        if (sbe1[b]) mem1[saddr1][b*8 +: 8] <= swd1[b*8 +: 8];
    end
    if (sreq1 && !swe1) rdata1 <= mem1[saddr1];
    r2_0 <= pat(saddr2);
    r2_1 <= r2_0;
    r3_0 <= pat(saddr3);
    r3_1 <= r3_0;
    r3_2 <= r3_1;
  end
  assign rdata2 = r2_1;
  assign rdata3 = r3_2;

  // Scoreboards
  always @(negedge clk) begin : mon1
    logic [EW-1:0] e;
    if (!rst) begin
      if (exp_q1.size() > 0 && int'(exp_q1[0][EW-1 -: 32]) == cyc) begin
        e = exp_q1.pop_front();
        chk_cnt++;
        if (rspv1 !== e[131:128] || rdo1 !== e[127:0])
          $display("FAIL rsp1 cyc %0d: got v=%b d=%h expected v=%b d=%h", cyc, rspv1, rdo1, e[131:128], e[127:0]);
        else pass_cnt++;
      end else if (rspv1 !== 4'b0) begin
        chk_cnt++;
        $display("FAIL rsp1_unexpected cyc %0d: got v=%b expected 0000", cyc, rspv1);
      end
    end
  end

  always @(negedge clk) begin : mon2
    logic [EW-1:0] e;
    if (!rst) begin
      if (exp_q2.size() > 0 && int'(exp_q2[0][EW-1 -: 32]) == cyc) begin
        e = exp_q2.pop_front();
        chk_cnt++;
        if (rspv2 !== e[131:128] || rdo2 !== e[127:0])
          $display("FAIL rsp2 cyc %0d: got v=%b d=%h expected v=%b d=%h", cyc, rspv2, rdo2, e[131:128], e[127:0]);
        else pass_cnt++;
      end else if (rspv2 !== 4'b0) begin
        chk_cnt++;
        $display("FAIL rsp2_unexpected cyc %0d: got v=%b expected 0000", cyc, rspv2);
      end
    end
  end

  always @(negedge clk) begin : mon3
    logic [EW-1:0] e;
    if (!rst) begin
      if (exp_q3.size() > 0 && int'(exp_q3[0][EW-1 -: 32]) == cyc) begin
        e = exp_q3.pop_front();
        chk_cnt++;
        if (rspv3 !== e[131:128] || rdo3 !== e[127:0])
          $display("FAIL rsp3 cyc %0d: got v=%b d=%h expected v=%b d=%h", cyc, rspv3, rdo3, e[131:128], e[127:0]);
        else pass_cnt++;
      end else if (rspv3 !== 4'b0) begin
        chk_cnt++;
        $display("FAIL rsp3_unexpected cyc %0d: got v=%b expected 0000", cyc, rspv3);
      end
    end
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    valid1 = 4'hF; valid2 = 4'hF; valid3 = 4'hF; we = 4'h0;
    for (int i = 0; i < 4; i++) addr[i] = 10'($urandom_range(16, 1023));
    repeat (2) @(negedge clk);
    chk_cnt++; if (ready1 !== 4'b0) $display("FAIL reset_ready1: got %b expected 0000", ready1); else pass_cnt++;
    chk_cnt++; if (ready3 !== 4'b0) $display("FAIL reset_ready3: got %b expected 0000", ready3); else pass_cnt++;
    chk_cnt++; if (sreq1 !== 1'b0) $display("FAIL reset_sram_req: got %b expected 0", sreq1); else pass_cnt++;
    chk_cnt++; if (saddr1 !== 10'd0) $display("FAIL reset_sram_addr: got %h expected 000", saddr1); else pass_cnt++;
    chk_cnt++; if (rspv1 !== 4'b0) $display("FAIL reset_rsp_valid: got %b expected 0000", rspv1); else pass_cnt++;
    chk_cnt++; if (rr1 !== 2'd3) $display("FAIL reset_rr: got %0d expected 3", rr1); else pass_cnt++;
    chk_cnt++; if (rdo1 !== rdata1) $display("FAIL reset_rdata_pass: got %h expected %h", rdo1, rdata1); else pass_cnt++;
    next_cycle();
    rst = 1'b0; valid2 = 4'h0; valid3 = 4'h0;
    exp_q1.push_back(mk(cyc + 1, 4'b0001, pat(addr[0])));
    @(negedge clk);
    chk_cnt++; if (ready1 !== 4'b0001) $display("FAIL release_grant: got %b expected 0001", ready1); else pass_cnt++;
    chk_cnt++; if (saddr1 !== addr[0]) $display("FAIL release_addr: got %h expected %h", saddr1, addr[0]); else pass_cnt++;
    next_cycle();
    valid1 = 4'h0;
  endtask

  task automatic test_write_read();
    valid1 = 4'b0100; we = 4'b0100; addr[2] = 10'h05; wdata[2] = {16{8'hA5}}; be[2] = 16'hFFFF;
    @(negedge clk);
    chk_cnt++; if (ready1 !== 4'b0100) $display("FAIL wr_grant: got %b expected 0100", ready1); else pass_cnt++;
    chk_cnt++; if (swe1 !== 1'b1) $display("FAIL wr_we: got %b expected 1", swe1); else pass_cnt++;
    chk_cnt++; if (saddr1 !== 10'h05) $display("FAIL wr_addr: got %h expected 005", saddr1); else pass_cnt++;
    chk_cnt++; if (swd1 !== {16{8'hA5}}) $display("FAIL wr_wdata: got %h expected a5..a5", swd1); else pass_cnt++;
    chk_cnt++; if (sbe1 !== 16'hFFFF) $display("FAIL wr_be: got %h expected ffff", sbe1); else pass_cnt++;
    next_cycle();
    we = 4'b0000;
    exp_q1.push_back(mk(cyc + 1, 4'b0100, {16{8'hA5}}));
    @(negedge clk);
    chk_cnt++; if (ready1 !== 4'b0100) $display("FAIL rd_grant: got %b expected 0100", ready1); else pass_cnt++;
    chk_cnt++; if (swe1 !== 1'b0) $display("FAIL rd_we: got %b expected 0", swe1); else pass_cnt++;
    next_cycle();
    valid1 = 4'h0; be[2] = 16'h0; wdata[2] = '0;
  endtask

  task automatic test_contention();
    logic [3:0] oh;
    for (int i = 0; i < 4; i++) addr[i] = 10'($urandom_range(16, 1023));
    valid1 = 4'b1000;
    exp_q1.push_back(mk(cyc + 1, 4'b1000, pat(addr[3])));
    @(negedge clk);
    chk_cnt++; if (ready1 !== 4'b1000) $display("FAIL pre_contention_grant: got %b expected 1000", ready1); else pass_cnt++;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      valid1 = 4'hF;
      oh = 4'b0001 << (c % 4);
      exp_q1.push_back(mk(cyc + 1, oh, pat(addr[c % 4])));
      @(negedge clk);
      chk_cnt++;
      if (ready1 !== oh) $display("FAIL contention_grant_%0d: got %b expected %b", c, ready1, oh);
      else pass_cnt++;
    end
    next_cycle();
  endtask

  task automatic test_sparse();
    logic [3:0] oh;
    for (int c = 0; c < 4; c++) begin
      valid1 = 4'b1010;
      oh = (c % 2 == 1) ? 4'b1000 : 4'b0010;
      exp_q1.push_back(mk(cyc + 1, oh, pat(addr[(c % 2 == 1) ? 3 : 1])));
      @(negedge clk);
      chk_cnt++;
      if (ready1 !== oh) $display("FAIL sparse_grant_%0d: got %b expected %b", c, ready1, oh);
      else pass_cnt++;
      next_cycle();
    end
  endtask

  task automatic test_idle();
    valid1 = 4'h0;
    @(negedge clk);
    chk_cnt++; if (ready1 !== 4'b0) $display("FAIL idle_ready: got %b expected 0000", ready1); else pass_cnt++;
    chk_cnt++; if (sreq1 !== 1'b0) $display("FAIL idle_sram_req: got %b expected 0", sreq1); else pass_cnt++;
    chk_cnt++; if (saddr1 !== 10'd0 || swe1 !== 1'b0) $display("FAIL idle_sram_drive: got a=%h we=%b expected 000/0", saddr1, swe1); else pass_cnt++;
    next_cycle();
    @(negedge clk);
    chk_cnt++; if (rr1 !== 2'd3) $display("FAIL idle_rr_hold: got %0d expected 3", rr1); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_latency3();
    for (int i = 0; i < 4; i++) addr[i] = 10'($urandom_range(16, 1023));
    valid3 = 4'b0001; we = 4'h0;
    exp_q3.push_back(mk(cyc + 3, 4'b0001, pat(addr[0])));
    @(negedge clk);
    chk_cnt++; if (ready3 !== 4'b0001) $display("FAIL lat3_grant0: got %b expected 0001", ready3); else pass_cnt++;
    next_cycle();
    valid3 = 4'b0010;
    exp_q3.push_back(mk(cyc + 3, 4'b0010, pat(addr[1])));
    @(negedge clk);
    chk_cnt++; if (ready3 !== 4'b0010) $display("FAIL lat3_grant1: got %b expected 0010", ready3); else pass_cnt++;
    next_cycle();
    valid3 = 4'h0;
    repeat (4) next_cycle();
  endtask

  task automatic test_reset_midflight();
    valid2 = 4'b0001;
    @(negedge clk);
    chk_cnt++; if (ready2 !== 4'b0001) $display("FAIL mid_grant: got %b expected 0001", ready2); else pass_cnt++;
    next_cycle();
    valid2 = 4'h0; rst = 1'b1;
    @(negedge clk);
    chk_cnt++; if (rr2 !== 2'd3) $display("FAIL mid_rr_reset: got %0d expected 3", rr2); else pass_cnt++;
    chk_cnt++; if (rspv2 !== 4'b0) $display("FAIL mid_rsp_in_reset: got %b expected 0000", rspv2); else pass_cnt++;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++; if (rspv2 !== 4'b0) $display("FAIL mid_dropped_read: got %b expected 0000", rspv2); else pass_cnt++;
    next_cycle();
    valid2 = 4'b0011;
    exp_q2.push_back(mk(cyc + 2, 4'b0001, pat(addr[0])));
    @(negedge clk);
    chk_cnt++; if (ready2 !== 4'b0001) $display("FAIL post_reset_grant: got %b expected 0001", ready2); else pass_cnt++;
    next_cycle();
    valid2 = 4'h0;
    repeat (3) next_cycle();
  endtask

  initial begin
    valid1 = '0; valid2 = '0; valid3 = '0; we = '0; addr = '0; wdata = '0; be = '0;
    test_reset();
    test_write_read();
    test_contention();
    test_sparse();
    test_idle();
    test_latency3();
    test_reset_midflight();
    repeat (3) next_cycle();
    chk_cnt++; if (exp_q1.size() != 0) $display("FAIL drain_q1: got %0d pending expected 0", exp_q1.size()); else pass_cnt++;
    chk_cnt++; if (exp_q2.size() != 0) $display("FAIL drain_q2: got %0d pending expected 0", exp_q2.size()); else pass_cnt++;
    chk_cnt++; if (exp_q3.size() != 0) $display("FAIL drain_q3: got %0d pending expected 0", exp_q3.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
